// File: rtl/wrap_event_monitor_if.sv
// Bus bundle between the counter-side driver and the wrap event monitor.
// The master drives the count stream and handshake requests; the slave reports status.
interface wrap_event_monitor_if #(
  parameter int WRAP_W = 8
);
  logic [3:0]        cnt_in;
  logic              cnt_valid;
  logic              start;
  logic              ack;
  logic [WRAP_W-1:0] wraps;
  logic              err_jump;
  logic              busy;
  logic              done;

  modport master (
    output cnt_in, cnt_valid, start, ack,
    input  wraps, err_jump, busy, done
  );

  modport slave (
    input  cnt_in, cnt_valid, start, ack,
    output wraps, err_jump, busy, done
  );
endinterface

// File: rtl/wrap_event_monitor.sv
// Watches a 4-bit binary count stream, tallies 15->0 wraps, flags illegal jumps,
// and raises done once TARGET wraps have been seen in a run.
module wrap_event_monitor #(
  parameter int WRAP_W = 8,
  parameter int TARGET = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  wrap_event_monitor_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WRAP_W-1:0] TARGET_W = WRAP_W'(TARGET);

  state_t            state_q, state_d;
  logic [3:0]        prev_q, prev_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [3:0]        prev_inc;

  // Saturating increment of the wrap tally.
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] val);
    if (&val) begin
      return val;
    end
    return val + 1'b1;
  endfunction

  assign prev_inc = prev_q + 4'd1;

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    wraps_d = wraps_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_ARM;
          wraps_d = '0;
          err_d   = 1'b0;
        end
      end

      S_ARM: begin
        if (bus.cnt_valid) begin
          prev_d  = bus.cnt_in;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (bus.cnt_valid) begin
          prev_d = bus.cnt_in;
          if (bus.cnt_in == prev_q) begin
            prev_d = prev_q;
          end else if ((prev_q != 4'd15) && (bus.cnt_in == prev_inc)) begin
            prev_d = bus.cnt_in;
          end else if ((prev_q == 4'd15) && (bus.cnt_in == 4'd0)) begin
            // Wrap takes priority; completion is judged on the post-increment tally.
            wraps_d = sat_inc(wraps_q);
            if (wraps_d == TARGET_W) begin
              state_d = S_DONE;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        if (bus.ack) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_ARM) || (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      prev_q  <= '0;
      wraps_q <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      wraps_q <= wraps_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.wraps    = wraps_q;
  assign bus.err_jump = err_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_wrap_event_monitor.sv
// Directed bench for wrap_event_monitor: reset, nominal run, gaps/holds, illegal
// jumps, handshake and ARM-sample behaviour with hand-computed expectations.
module tb_wrap_event_monitor;

  localparam int WRAP_W = 8;
  localparam int TARGET = 3;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  wrap_event_monitor_if #(.WRAP_W(WRAP_W)) bus ();

  wrap_event_monitor #(.WRAP_W(WRAP_W), .TARGET(TARGET)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stream input, then settle 1 time unit past the edge.
  task automatic feed(input logic [3:0] v, input logic vl);
    bus.cnt_in    = v;
    bus.cnt_valid = vl;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.wraps !== 8'd0) begin
      failures++; $display("FAIL reset_wraps: got %0d want 0", bus.wraps);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL reset_done: got %b want 0", bus.done);
    end
    checks++;
    if (bus.err_jump !== 1'b0) begin
      failures++; $display("FAIL reset_err: got %b want 0", bus.err_jump);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_nominal();
    bus.start = 1'b1;
    feed(4'd0, 1'b0);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL nom_arm_busy: got %b want 1", bus.busy);
    end
    for (int i = 0; i <= 48; i++) begin
      feed(4'(i % 16), 1'b1);
      if (i == 15) begin
        checks++;
        if (bus.wraps !== 8'd0) begin
          failures++; $display("FAIL nom_prewrap: got %0d want 0", bus.wraps);
        end
      end
      if (i == 16 || i == 32) begin
        checks++;
        if (bus.wraps !== 8'(i / 16)) begin
          failures++; $display("FAIL nom_wraps_%0d: got %0d want %0d", i, bus.wraps, i / 16);
        end
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          failures++; $display("FAIL nom_midrun_%0d: got done=%b busy=%b want done=0 busy=1", i, bus.done, bus.busy);
        end
      end
    end
    checks++;
    if (bus.wraps !== 8'd3) begin
      failures++; $display("FAIL nom_final_wraps: got %0d want 3", bus.wraps);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL nom_done: got done=%b busy=%b want done=1 busy=0", bus.done, bus.busy);
    end
    checks++;
    if (bus.err_jump !== 1'b0) begin
      failures++; $display("FAIL nom_err: got %b want 0", bus.err_jump);
    end
    bus.ack = 1'b1;
    feed(4'd1, 1'b1);
    bus.ack = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.wraps !== 8'd3) begin
      failures++; $display("FAIL nom_ack: got done=%b busy=%b wraps=%0d want 0 0 3", bus.done, bus.busy, bus.wraps);
    end
  endtask

  task automatic test_gaps_holds();
    bus.start = 1'b1;
    feed(4'd0, 1'b0);
    bus.start = 1'b0;
    for (int i = 0; i <= 48; i++) begin
      feed(4'(i % 16), 1'b1);
      if (i % 16 == 5) begin
        feed(4'd5, 1'b1);
        feed(4'd5, 1'b1);
      end
      if (i == 16 || i == 32) begin
        checks++;
        if (bus.wraps !== 8'(i / 16)) begin
          failures++; $display("FAIL gap_wraps_%0d: got %0d want %0d", i, bus.wraps, i / 16);
        end
      end
      if (i < 48) begin
        feed(4'd9, 1'b0);
      end
    end
    checks++;
    if (bus.wraps !== 8'd3 || bus.done !== 1'b1) begin
      failures++; $display("FAIL gap_done: got wraps=%0d done=%b want 3 1", bus.wraps, bus.done);
    end
    checks++;
    if (bus.err_jump !== 1'b0) begin
      failures++; $display("FAIL gap_err: got %b want 0", bus.err_jump);
    end
    bus.ack = 1'b1;
    feed(4'd0, 1'b0);
    bus.ack = 1'b0;
    checks++;
    if (bus.done !== 1'b0) begin
      failures++; $display("FAIL gap_ack: got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_illegal_jump();
    bus.start = 1'b1;
    feed(4'd0, 1'b0);
    bus.start = 1'b0;
    feed(4'd0, 1'b1);
    feed(4'd1, 1'b1);
    feed(4'd2, 1'b1);
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    feed(4'd3, 1'b1);
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.wraps !== 8'd0) begin
      failures++; $display("FAIL ill_ignore_req: got busy=%b wraps=%0d want 1 0", bus.busy, bus.wraps);
    end
    checks++;
    if (bus.err_jump !== 1'b0) begin
      failures++; $display("FAIL ill_before: got %b want 0", bus.err_jump);
    end
    feed(4'd7, 1'b1);
    checks++;
    if (bus.err_jump !== 1'b1 || bus.wraps !== 8'd0) begin
      failures++; $display("FAIL ill_jump: got err=%b wraps=%0d want 1 0", bus.err_jump, bus.wraps);
    end
    for (int i = 8; i <= 48; i++) begin
      feed(4'(i % 16), 1'b1);
      if (i == 16) begin
        checks++;
        if (bus.wraps !== 8'd1 || bus.err_jump !== 1'b1) begin
          failures++; $display("FAIL ill_wrap1: got wraps=%0d err=%b want 1 1", bus.wraps, bus.err_jump);
        end
      end
    end
    checks++;
    if (bus.done !== 1'b1 || bus.wraps !== 8'd3 || bus.err_jump !== 1'b1) begin
      failures++; $display("FAIL ill_done: got done=%b wraps=%0d err=%b want 1 3 1", bus.done, bus.wraps, bus.err_jump);
    end
    bus.ack = 1'b1;
    feed(4'd0, 1'b0);
    bus.ack = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.err_jump !== 1'b1) begin
      failures++; $display("FAIL ill_idle_keep: got done=%b err=%b want 0 1", bus.done, bus.err_jump);
    end
    bus.start = 1'b1;
    feed(4'd0, 1'b0);
    bus.start = 1'b0;
    checks++;
    if (bus.err_jump !== 1'b0 || bus.wraps !== 8'd0 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL ill_restart: got err=%b wraps=%0d busy=%b want 0 0 1", bus.err_jump, bus.wraps, bus.busy);
    end
  endtask

  task automatic test_midrun_reset();
    for (int i = 0; i <= 34; i++) begin
      feed(4'(i % 16), 1'b1);
    end
    checks++;
    if (bus.wraps !== 8'd2 || bus.busy !== 1'b1) begin
      failures++; $display("FAIL rst_pre: got wraps=%0d busy=%b want 2 1", bus.wraps, bus.busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.wraps !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_jump !== 1'b0) begin
      failures++; $display("FAIL rst_async: got wraps=%0d busy=%b done=%b err=%b want 0 0 0 0",
                           bus.wraps, bus.busy, bus.done, bus.err_jump);
    end
    #2;
    reset = 1'b1;
    feed(4'd3, 1'b1);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.wraps !== 8'd0) begin
      failures++; $display("FAIL rst_idle: got busy=%b done=%b wraps=%0d want 0 0 0", bus.busy, bus.done, bus.wraps);
    end
  endtask

  task automatic test_handshake();
    bus.start = 1'b1;
    feed(4'd0, 1'b0);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL hs_arm: got busy=%b want 1", bus.busy);
    end
    for (int i = 0; i <= 48; i++) begin
      feed(4'(i % 16), 1'b1);
    end
    checks++;
    if (bus.done !== 1'b1 || bus.wraps !== 8'd3) begin
      failures++; $display("FAIL hs_done: got done=%b wraps=%0d want 1 3", bus.done, bus.wraps);
    end
    for (int i = 49; i <= 68; i++) begin
      feed(4'(i % 16), 1'b1);
      checks++;
      if (bus.done !== 1'b1 || bus.wraps !== 8'd3 || bus.busy !== 1'b0) begin
        failures++; $display("FAIL hs_hold_%0d: got done=%b wraps=%0d busy=%b want 1 3 0", i, bus.done, bus.wraps, bus.busy);
      end
    end
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    feed(4'd0, 1'b0);
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.wraps !== 8'd3) begin
      failures++; $display("FAIL hs_ack_start: got done=%b busy=%b wraps=%0d want 0 0 3", bus.done, bus.busy, bus.wraps);
    end
    bus.start = 1'b1;
    feed(4'd0, 1'b0);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.wraps !== 8'd0) begin
      failures++; $display("FAIL hs_rearm: got busy=%b wraps=%0d want 1 0", bus.busy, bus.wraps);
    end
  endtask

  task automatic test_arm_edge();
    feed(4'd15, 1'b0);
    feed(4'd15, 1'b0);
    feed(4'd15, 1'b0);
    feed(4'd0, 1'b1);
    checks++;
    if (bus.wraps !== 8'd0 || bus.busy !== 1'b1 || bus.err_jump !== 1'b0) begin
      failures++; $display("FAIL arm_first: got wraps=%0d busy=%b err=%b want 0 1 0", bus.wraps, bus.busy, bus.err_jump);
    end
    for (int i = 1; i <= 16; i++) begin
      feed(4'(i % 16), 1'b1);
    end
    checks++;
    if (bus.wraps !== 8'd1 || bus.err_jump !== 1'b0) begin
      failures++; $display("FAIL arm_wrap: got wraps=%0d err=%b want 1 0", bus.wraps, bus.err_jump);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    bus.cnt_in    = 4'd0;
    bus.cnt_valid = 1'b0;
    bus.start     = 1'b0;
    bus.ack       = 1'b0;
    test_reset();
    test_nominal();
    test_gaps_holds();
    test_illegal_jump();
    test_midrun_reset();
    test_handshake();
    test_arm_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
